pc_flow_ctrl: RTL
=================

// Module: pc_flow_ctrl
// PURPOSE
//  Front-end flow controller for the 5-stage pipeline. Owns the architectural PC register and drives
//  op/stop into the next-PC adder.
//  Takes EX-stage control-transfer info, ID/EX load-use operands and a memory busy flag, then produces
//  the IF/ID and ID/EX hold/flush controls.
//  Sits between the next-PC unit, the pipeline registers and the hazard sources.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset
//  BOOT_CYCLES  4              cycles the front end stays frozen after reset release (>=1)
//  LU_CYCLES    1              total stall cycles for one load-use hazard (>=1)
//  TRAP_VEC     32'h0000_0100  misaligned-target vector (used only with PC_MISALIGN_TRAP_EN)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  npc            in   32  next PC from the next-PC unit (already computed from npc_op/stop)
//  ex_valid       in   1   EX holds a real instruction (not a bubble)
//  ex_is_jal      in   1   EX instruction is JAL
//  ex_is_jalr     in   1   EX instruction is JALR
//  ex_is_branch   in   1   EX instruction is a B-type instruction
//  ex_br_taken    in   1   B-type condition true
//  ex_is_load     in   1   EX instruction is a load
//  ex_rd          in   5   EX destination register
//  id_rs1/id_rs2  in   5   ID source registers
//  id_use_rs1/2   in   1   ID instruction reads rs1/rs2
//  mem_busy       in   1   data/instr memory wait; freezes the whole pipe
//  if_pc          out  32  current fetch PC (registered)
//  npc_op         out  2   00 seq, 01 jalr, 10 branch, 11 jal
//  stop           out  1   next-PC unit holds PC (npc = if_pc)
//  ifid_hold      out  1   IF/ID keeps its contents
//  ifid_flush     out  1   IF/ID loads a bubble
//  idex_hold      out  1   ID/EX keeps its contents
//  idex_flush     out  1   ID/EX loads a bubble
//  misalign_trap  out  1   1-cycle pulse on misaligned redirect target
// BEHAVIOUR
//  FSM states:
//   BOOT: reset state; counter = BOOT_CYCLES-1.
//   RUN: normal fetch.
//   LU_STALL: extra load-use cycles.
//  Reset (async):
//   if_pc = RESET_PC; state = BOOT; lu counter = 0.
//   Outputs in BOOT: stop=1, npc_op=00, ifid_flush=1, idex_flush=1, all holds 0, misalign_trap=0.
//  BOOT: counter decrements each cycle. At 0 -> RUN. if_pc is held at RESET_PC throughout.
//  redirect = ex_valid & (ex_is_jal | ex_is_jalr | ex_is_branch & ex_br_taken).
//  npc_op (when ex_valid and not mem_busy): jal 11, jalr 01, branch 10, else 00.
//  Load-use hazard:
//   lu = ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  Priority in RUN: mem_busy > redirect > lu.
//   mem_busy:
//    - stop=1, npc_op=00, ifid_hold=1, idex_hold=1, no flush.
//    - Any redirect is deferred: EX is frozen and re-presents it when mem_busy drops.
//   redirect:
//    - stop=0; ifid_flush=1, idex_flush=1 in the same cycle.
//    - if_pc <= npc at the next edge.
//    - lu is ignored, because the ID instruction is wrong-path.
//   lu:
//    - stop=1, ifid_hold=1, idex_flush=1 (bubble).
//    - If LU_CYCLES>1, go to LU_STALL with counter = LU_CYCLES-2.
//   else: stop=0, if_pc <= npc (if_pc+4).
//  LU_STALL:
//   - Same outputs as lu.
//   - Counter decrements; at 0 -> RUN.
//   - mem_busy pauses the counter and applies mem_busy outputs.
//  if_pc <= npc every edge outside BOOT. When stop=1, npc==if_pc, so no extra gating is needed.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined:
//   - A redirect with npc[1:0]!=0 loads if_pc <= TRAP_VEC.
//   - misalign_trap pulses for that cycle; both flushes asserted.
//  PC_MISALIGN_TRAP_EN undefined:
//   - npc is loaded unchanged.
//   - misalign_trap is tied to 0.
// STRUCTURE
//  Shared package: npc_op encodings (NPC_SEQ/JALR/BR/JAL), FSM state enum, XLEN=32.
//  Sub-module lu_detect: pure combinational load-use comparator, instantiated once.
// TESTING
//  1. Reset, hold rst 3 cycles, release:
//     - if_pc==0 and flushes==1 for 4 cycles, then if_pc steps 0,4,8.
//  2. JAL in EX at ex_pc=0x20, imm=0x40:
//     - npc_op=11, ifid_flush=idex_flush=1.
//     - Next cycle if_pc==0x60.
//  3. Load x5 in EX, ID reads x5:
//     - stop=1, ifid_hold=1, idex_flush=1 for exactly LU_CYCLES cycles.
//     - With ex_rd=0: no stall.
//  4. Taken branch and lu in the same cycle:
//     - Flush only, no stall, if_pc==branch target.
//  5. mem_busy held 3 cycles while JALR is in EX:
//     - if_pc frozen, holds=1, no flush.
//     - Redirect occurs on the cycle busy drops.
//  6. PC_MISALIGN_TRAP_EN, JALR target 0x102:
//     - misalign_trap=1 for 1 cycle, if_pc==0x100.
//     - Without the macro: if_pc==0x102.

Source files
------------

// File: rtl/pc_flow_ctrl_pkg.sv
// Shared definitions for the pipeline front-end flow controller:
// datapath width, next-PC operation encodings, FSM states and a
// small address-alignment helper.
package pc_flow_ctrl_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        NPC_SEQ  = 2'b00,
        NPC_JALR = 2'b01,
        NPC_BR   = 2'b10,
        NPC_JAL  = 2'b11
    } npc_op_e;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_LU_STALL = 2'b10
    } fc_state_e;

    // A fetch target is misaligned when it is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_flow_ctrl_if.sv
// Signal bundle between the flow controller and its surroundings
// (next-PC unit, EX/ID hazard sources, pipeline registers).
// master: the flow controller itself. slave: the environment.
interface pc_flow_ctrl_if;
    import pc_flow_ctrl_pkg::*;

    logic [XLEN-1:0] npc;
    logic            ex_valid;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic            ex_is_branch;
    logic            ex_br_taken;
    logic            ex_is_load;
    logic [4:0]      ex_rd;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            mem_busy;

    logic [XLEN-1:0] if_pc;
    logic [1:0]      npc_op;
    logic            stop;
    logic            ifid_hold;
    logic            ifid_flush;
    logic            idex_hold;
    logic            idex_flush;
    logic            misalign_trap;

    modport master (
        input  npc, ex_valid, ex_is_jal, ex_is_jalr, ex_is_branch, ex_br_taken,
               ex_is_load, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, mem_busy,
        output if_pc, npc_op, stop, ifid_hold, ifid_flush, idex_hold, idex_flush,
               misalign_trap
    );

    modport slave (
        output npc, ex_valid, ex_is_jal, ex_is_jalr, ex_is_branch, ex_br_taken,
               ex_is_load, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, mem_busy,
        input  if_pc, npc_op, stop, ifid_hold, ifid_flush, idex_hold, idex_flush,
               misalign_trap
    );

endinterface

// File: rtl/pc_flow_ctrl_lu_detect.sv
// Load-use hazard comparator: the ID instruction reads a register that
// the load currently in EX has not yet written. x0 never creates a hazard.
module lu_detect (
    input  logic       ex_valid_i,
    input  logic       ex_is_load_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    output logic       lu_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1_i & (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_use_rs2_i & (id_rs2_i == ex_rd_i);
    assign lu_o    = ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pc_flow_ctrl.sv
// Front-end flow controller: owns the fetch PC, tells the next-PC unit
// what to compute (npc_op/stop) and drives IF/ID and ID/EX hold/flush.
// Priority while running: memory wait > control-transfer redirect > load-use.
// Optional feature macro: PC_MISALIGN_TRAP_EN -- a redirect to a
// non-word-aligned target is replaced by TRAP_VEC and flagged on
// misalign_trap. Without it the target is taken as-is and the flag is 0.
module pc_flow_ctrl
    import pc_flow_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              BOOT_CYCLES = 4,
    parameter int              LU_CYCLES   = 1
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VEC    = 32'h0000_0100
`endif
) (
    input  logic          clk,
    input  logic          rst,
    pc_flow_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] BOOT_INIT = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LU_INIT   = (LU_CYCLES > 1) ? CNT_W'(LU_CYCLES - 2) : '0;
    localparam logic             LU_MULTI  = (LU_CYCLES > 1);

    fc_state_e        state_q, state_d;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [XLEN-1:0]  pc_q, pc_d;

    npc_op_e          op_sel;
    npc_op_e          npc_op_w;
    logic             redirect;
    logic             lu_hit;
    logic             stop_w;
    logic             ifid_hold_w;
    logic             ifid_flush_w;
    logic             idex_hold_w;
    logic             idex_flush_w;
    logic             trap_w;

    assign redirect = bus.ex_valid &
                      (bus.ex_is_jal | bus.ex_is_jalr | (bus.ex_is_branch & bus.ex_br_taken));

    lu_detect u_lu_detect (
        .ex_valid_i   (bus.ex_valid),
        .ex_is_load_i (bus.ex_is_load),
        .ex_rd_i      (bus.ex_rd),
        .id_rs1_i     (bus.id_rs1),
        .id_rs2_i     (bus.id_rs2),
        .id_use_rs1_i (bus.id_use_rs1),
        .id_use_rs2_i (bus.id_use_rs2),
        .lu_o         (lu_hit)
    );

    // Decode the EX control-transfer kind into the next-PC operation.
    always_comb begin
        op_sel = NPC_SEQ;
        if (bus.ex_valid) begin
            if (bus.ex_is_jal) begin
                op_sel = NPC_JAL;
            end else if (bus.ex_is_jalr) begin
                op_sel = NPC_JALR;
            end else if (bus.ex_is_branch) begin
                op_sel = NPC_BR;
            end else begin
                op_sel = NPC_SEQ;
            end
        end else begin
            op_sel = NPC_SEQ;
        end
    end

    // Next-state, counter, PC and pipeline-control decode.
    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        lu_cnt_d     = lu_cnt_q;
        pc_d         = pc_q;
        npc_op_w     = NPC_SEQ;
        stop_w       = 1'b0;
        ifid_hold_w  = 1'b0;
        ifid_flush_w = 1'b0;
        idex_hold_w  = 1'b0;
        idex_flush_w = 1'b0;
        trap_w       = 1'b0;

        case (state_q)
            ST_BOOT: begin
                stop_w       = 1'b1;
                ifid_flush_w = 1'b1;
                idex_flush_w = 1'b1;
                pc_d         = RESET_PC;
                if (boot_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (bus.mem_busy) begin
                    // Whole pipe frozen; EX re-presents any redirect later.
                    stop_w      = 1'b1;
                    ifid_hold_w = 1'b1;
                    idex_hold_w = 1'b1;
                    pc_d        = bus.npc;
                end else if (redirect) begin
                    // ID holds a wrong-path instruction, so load-use is moot.
                    npc_op_w     = op_sel;
                    ifid_flush_w = 1'b1;
                    idex_flush_w = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
                    if (is_misaligned(bus.npc)) begin
                        pc_d   = TRAP_VEC;
                        trap_w = 1'b1;
                    end else begin
                        pc_d = bus.npc;
                    end
`else
                    pc_d = bus.npc;
`endif
                end else if (lu_hit) begin
                    npc_op_w     = op_sel;
                    stop_w       = 1'b1;
                    ifid_hold_w  = 1'b1;
                    idex_flush_w = 1'b1;
                    pc_d         = bus.npc;
                    if (LU_MULTI) begin
                        state_d  = ST_LU_STALL;
                        lu_cnt_d = LU_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    npc_op_w = op_sel;
                    pc_d     = bus.npc;
                end
            end

            ST_LU_STALL: begin
                pc_d = bus.npc;
                if (bus.mem_busy) begin
                    // Memory wait pauses the stall count.
                    stop_w      = 1'b1;
                    ifid_hold_w = 1'b1;
                    idex_hold_w = 1'b1;
                end else begin
                    npc_op_w     = op_sel;
                    stop_w       = 1'b1;
                    ifid_hold_w  = 1'b1;
                    idex_flush_w = 1'b1;
                    if (lu_cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        lu_cnt_d = lu_cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                // Unreachable encoding: restart the boot sequence.
                state_d      = ST_BOOT;
                boot_cnt_d   = BOOT_INIT;
                lu_cnt_d     = '0;
                pc_d         = RESET_PC;
                stop_w       = 1'b1;
                ifid_flush_w = 1'b1;
                idex_flush_w = 1'b1;
            end
        endcase
    end

    // State, counters and fetch PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BOOT_INIT;
            lu_cnt_q   <= '0;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            lu_cnt_q   <= lu_cnt_d;
            pc_q       <= pc_d;
        end
    end

    assign bus.if_pc         = pc_q;
    assign bus.npc_op        = npc_op_w;
    assign bus.stop          = stop_w;
    assign bus.ifid_hold     = ifid_hold_w;
    assign bus.ifid_flush    = ifid_flush_w;
    assign bus.idex_hold     = idex_hold_w;
    assign bus.idex_flush    = idex_flush_w;
    assign bus.misalign_trap = trap_w;

endmodule
